// File: rtl/array_multiplier.sv
// Unsigned WIDTH x WIDTH carry-save array multiplier with a registered product and valid strobe.
// Define ARRAY_MULTIPLIER_PIPE_EN to add a stage register after row WIDTH/2 (latency 2 instead of 1).
module array_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 in_valid,
    output logic [2*WIDTH-1:0]   p,
    output logic                 out_valid
);

    localparam int W = WIDTH;
    localparam int H = WIDTH / 2;

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    logic [W-1:0]   pp    [W];
    logic [W-1:0]   s_row [W];
    logic [W-1:0]   c_row [W];
    logic [W-1:0]   lo;
    logic [W-1:0]   hi;
    logic [W-2:0]   s_fin;
    logic [W-1:0]   c_fin;
    logic           cr    [1:W-1];
    logic [2*W-1:0] prod;

`ifdef ARRAY_MULTIPLIER_PIPE_EN
    localparam int BHW = (W - H - 1 > 0) ? W - H - 1 : 1;

    logic           stage_valid;
    logic [W-1:0]   a_q;
    logic [BHW-1:0] b_up;
    logic [BHW-1:0] b_hi;
    logic [W-2:0]   s_q;
    logic [W-1:0]   c_q;
    logic [H:0]     lo_pre;
    logic [H:0]     lo_q;

    // Multiplier bits consumed only by the rows after the stage register.
    if (H < W - 1) begin : g_bup
        assign b_up = b[W-1:H+1];
    end else begin : g_bup_none
        assign b_up = '0;
    end

    for (genvar k = 0; k <= H; k++) begin : g_lo_pre
        assign lo_pre[k] = s_row[k][0];
    end
`endif

    for (genvar i = 0; i < W; i++) begin : g_pp
`ifdef ARRAY_MULTIPLIER_PIPE_EN
        if (i <= H) begin : g_front
            assign pp[i] = a & {W{b[i]}};
        end else begin : g_back
            assign pp[i] = a_q & {W{b_hi[i-H-1]}};
        end
`else
        assign pp[i] = a & {W{b[i]}};
`endif
    end

    assign s_row[0] = pp[0];
    assign c_row[0] = '0;

    // Row i: sum bit j+1 and carry bit j of row i-1 both carry weight i+j, matching pp[i][j].
    for (genvar i = 1; i < W; i++) begin : g_row
        logic [W-2:0] s_in;
        logic [W-1:0] c_in;
        logic [W-1:0] s_o;
        logic [W-1:0] c_o;

`ifdef ARRAY_MULTIPLIER_PIPE_EN
        if (i == H + 1) begin : g_src_reg
            assign s_in = s_q;
            assign c_in = c_q;
        end else begin : g_src_row
            assign s_in = s_row[i-1][W-1:1];
            assign c_in = c_row[i-1];
        end
`else
        assign s_in = s_row[i-1][W-1:1];
        assign c_in = c_row[i-1];
`endif

        for (genvar j = 0; j < W; j++) begin : g_cell
            if (j == W - 1) begin : g_ha
                assign {c_o[j], s_o[j]} = half_add(pp[i][j], c_in[j]);
            end else begin : g_fa
                assign {c_o[j], s_o[j]} = full_add(pp[i][j], s_in[j], c_in[j]);
            end
        end

        assign s_row[i] = s_o;
        assign c_row[i] = c_o;
    end

    for (genvar k = 0; k < W; k++) begin : g_lo
`ifdef ARRAY_MULTIPLIER_PIPE_EN
        if (k <= H) begin : g_lo_reg
            assign lo[k] = lo_q[k];
        end else begin : g_lo_row
            assign lo[k] = s_row[k][0];
        end
`else
        assign lo[k] = s_row[k][0];
`endif
    end

`ifdef ARRAY_MULTIPLIER_PIPE_EN
    if (H == W - 1) begin : g_fin_reg
        assign s_fin = s_q;
        assign c_fin = c_q;
    end else begin : g_fin_row
        assign s_fin = s_row[W-1][W-1:1];
        assign c_fin = c_row[W-1];
    end
`else
    assign s_fin = s_row[W-1][W-1:1];
    assign c_fin = c_row[W-1];
`endif

    // Final ripple adder; the top bit needs no carry out since the product cannot overflow.
    for (genvar j = 0; j < W; j++) begin : g_rca
        if (j == 0) begin : g_first
            assign {cr[1], hi[0]} = half_add(s_fin[0], c_fin[0]);
        end else if (j < W - 1) begin : g_mid
            assign {cr[j+1], hi[j]} = full_add(s_fin[j], c_fin[j], cr[j]);
        end else begin : g_top
            assign hi[j] = c_fin[j] ^ cr[j];
        end
    end

    assign prod = {hi, lo};

`ifdef ARRAY_MULTIPLIER_PIPE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            a_q         <= '0;
            b_hi        <= '0;
            s_q         <= '0;
            c_q         <= '0;
            lo_q        <= '0;
        end else begin
            stage_valid <= in_valid;
            if (in_valid) begin
                a_q  <= a;
                b_hi <= b_up;
                s_q  <= s_row[H][W-1:1];
                c_q  <= c_row[H];
                lo_q <= lo_pre;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= stage_valid;
            if (stage_valid) begin
                p <= prod;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                p <= prod;
            end
        end
    end
`endif

endmodule

// File: tb/tb_array_multiplier.sv
// Self-checking bench for array_multiplier (4x4): directed table, sweeps, valid gaps and resets.
// Works for both the default and ARRAY_MULTIPLIER_PIPE_EN builds by tracking the latency.
module tb_array_multiplier;

`ifdef ARRAY_MULTIPLIER_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       in_valid = 1'b0;
    logic [7:0] p;
    logic       out_valid;

    int total = 0;
    int passed = 0;

    logic       mv [LAT];
    logic [7:0] mp [LAT];
    logic [7:0] exp_p;
    logic       exp_v;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    array_multiplier #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .p         (p),
        .out_valid (out_valid)
    );

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %b, expected %b", name, act, req);
    endtask

    task automatic model_reset();
        for (int k = 0; k < LAT; k++) begin
            mv[k] = 1'b0;
            mp[k] = '0;
        end
        exp_p = '0;
        exp_v = 1'b0;
    endtask

    // Drive one cycle of inputs, then compare against the latency-delayed model.
    task automatic step(input logic [3:0] av, input logic [3:0] bv, input logic vv,
                        input logic [7:0] ev, input string tag);
        a = av;
        b = bv;
        in_valid = vv;
        @(posedge clk);
        #1;
        for (int k = LAT - 1; k > 0; k--) begin
            mv[k] = mv[k-1];
            mp[k] = mp[k-1];
        end
        mv[0] = vv;
        mp[0] = ev;
        exp_v = mv[LAT-1];
        if (exp_v) exp_p = mp[LAT-1];
        check8({tag, " p"}, p, exp_p);
        check1({tag, " out_valid"}, out_valid, exp_v);
    endtask

    task automatic flush(input string tag);
        for (int k = 0; k < LAT + 1; k++) step(4'hF, 4'hF, 1'b0, 8'h00, tag);
    endtask

    initial begin
        vecs[0]  = '{4'd3,  4'd3,  8'h09};
        vecs[1]  = '{4'd10, 4'd10, 8'h64};
        vecs[2]  = '{4'd15, 4'd15, 8'hE1};
        vecs[3]  = '{4'd15, 4'd1,  8'h0F};
        vecs[4]  = '{4'd1,  4'd15, 8'h0F};
        vecs[5]  = '{4'd12, 4'd13, 8'h9C};
        vecs[6]  = '{4'd0,  4'd15, 8'h00};
        vecs[7]  = '{4'd9,  4'd0,  8'h00};
        vecs[8]  = '{4'd7,  4'd1,  8'h07};
        vecs[9]  = '{4'd5,  4'd6,  8'h1E};
        vecs[10] = '{4'd15, 4'd14, 8'hD2};
        vecs[11] = '{4'd2,  4'd8,  8'h10};

        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check8("reset p", p, 8'h00);
        check1("reset out_valid", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a cycle with a full-scale result on the output.
        step(4'hF, 4'hF, 1'b1, 8'hE1, "pre_rst");
        step(4'hF, 4'hF, 1'b1, 8'hE1, "pre_rst");
        #2 rst_n = 1'b0;
        #1;
        check8("async_rst p", p, 8'h00);
        check1("async_rst out_valid", out_valid, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step(4'hF, 4'hF, 1'b0, 8'h00, "post_rst");

        for (int i = 0; i < 12; i++) step(vecs[i].a, vecs[i].b, 1'b1, vecs[i].p, "vec");
        flush("vec_flush");

        for (int i = 0; i < 16; i++) begin
            logic [3:0] iv;
            logic [7:0] sq;
            iv = 4'(i);
            sq = 8'(i * i);
            step(iv, iv, 1'b1, sq, "square");
        end
        flush("square_flush");

        step(4'd5, 4'd6, 1'b1, 8'h1E, "gap");
        step(4'hF, 4'hF, 1'b0, 8'h00, "gap");
        step(4'hF, 4'hF, 1'b0, 8'h00, "gap");
        step(4'hF, 4'hF, 1'b0, 8'h00, "gap");
        check8("gap hold p", p, 8'h1E);

        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                step(4'(ia), 4'(ib), 1'b1, 8'(ia * ib), "exhaustive");
            end
        end
        flush("exhaustive_flush");

        // Reset while a result is still in flight: it must never emerge.
        step(4'd12, 4'd13, 1'b1, 8'h9C, "inflight");
        #2 rst_n = 1'b0;
        #1;
        check8("inflight_rst p", p, 8'h00);
        check1("inflight_rst out_valid", out_valid, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < LAT + 1; k++) step(4'd3, 4'd3, 1'b0, 8'h00, "dropped");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
